// File: rtl/reg_write_sequencer_pkg.sv
// Shared processor-wide definitions for the register write sequencer.
package reg_write_sequencer_pkg;

  // Opcodes in instr[15:12].
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_EXEC = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register block select encodings.
  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_OUT = 2'b10;

  // Instruction field bit positions.
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned DstMsb    = 11;
  localparam int unsigned DstLsb    = 10;
  localparam int unsigned ImmMsb    = 7;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned AluOpMsb  = 3;
  localparam int unsigned AluOpLsb  = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StAluStart,
    StAluWait,
    StWrite,
    StHalted
  } seq_state_e;

  // dst=11 has no register behind it.
  function automatic logic dst_is_legal(logic [1:0] dst);
    return (dst == SEL_A) || (dst == SEL_B) || (dst == SEL_OUT);
  endfunction

endpackage

// File: rtl/reg_write_sequencer_alu_timer.sv
// ALU wait timeout counter: cleared by load, counts while enabled, and flags the
// wait cycle in which the count reaches ALU_TIMEOUT.
module seq_alu_timer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LastCount = 8'(ALU_TIMEOUT - 1);

  logic [7:0] count_q;

  // Count wait cycles since the last load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (load_i) begin
      count_q <= 8'd0;
    end else if (en_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  // High in the wait cycle whose closing edge takes the count to ALU_TIMEOUT.
  always_comb begin
    expired_o = en_i && (count_q == LastCount);
  end

endmodule

// File: rtl/reg_write_sequencer.sv
// Instruction sequencer driving the general-purpose register block write port,
// with an ALU start/done handshake guarded by a timeout.
module reg_write_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15,
  parameter int unsigned DW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic [15:0]   instr_i,
  output logic          alu_start_o,
  output logic [3:0]    alu_op_o,
  input  logic          alu_done_i,
  input  logic [DW-1:0] alu_result_i,
  output logic          we_reg_o,
  output logic [1:0]    reg_select_o,
  output logic [DW-1:0] data_in_o,
  input  logic          resume_i,
  output logic          halted_o,
  output logic          err_o,
  output logic [7:0]    retired_count_o
);

  import reg_write_sequencer_pkg::*;

  seq_state_e    state_q;
  logic [15:0]   instr_q;
  logic          instr_ready_q;
  logic          alu_start_q;
  logic [3:0]    alu_op_q;
  logic          we_reg_q;
  logic [1:0]    reg_select_q;
  logic [DW-1:0] data_in_q;
  logic          halted_q;
  logic          err_q;
  logic [7:0]    retired_count_q;

  logic          timer_expired;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^instr_q[9:8];

  seq_alu_timer #(
    .ALU_TIMEOUT (ALU_TIMEOUT)
  ) u_alu_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == StAluStart),
    .en_i      (state_q == StAluWait),
    .expired_o (timer_expired)
  );

  // Sequencer FSM; every output is a register set on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StFetch;
      instr_q         <= 16'h0000;
      instr_ready_q   <= 1'b1;
      alu_start_q     <= 1'b0;
      alu_op_q        <= 4'h0;
      we_reg_q        <= 1'b0;
      reg_select_q    <= 2'b00;
      data_in_q       <= '0;
      halted_q        <= 1'b0;
      err_q           <= 1'b0;
      retired_count_q <= 8'd0;
    end else begin
      // Single-cycle strobes default low.
      alu_start_q <= 1'b0;
      we_reg_q    <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (instr_valid_i) begin
            instr_q       <= instr_i;
            instr_ready_q <= 1'b0;
            state_q       <= StDecode;
          end
        end
        StDecode: begin
          case (instr_q[OpcodeMsb:OpcodeLsb])
            OP_NOP: begin
              retired_count_q <= retired_count_q + 8'd1;
              instr_ready_q   <= 1'b1;
              state_q         <= StFetch;
            end
            OP_LDI: begin
              if (dst_is_legal(instr_q[DstMsb:DstLsb])) begin
                we_reg_q     <= 1'b1;
                reg_select_q <= instr_q[DstMsb:DstLsb];
                data_in_q    <= DW'(instr_q[ImmMsb:ImmLsb]);
                state_q      <= StWrite;
              end else begin
                err_q         <= 1'b1;
                instr_ready_q <= 1'b1;
                state_q       <= StFetch;
              end
            end
            OP_EXEC: begin
              alu_start_q <= 1'b1;
              alu_op_q    <= instr_q[AluOpMsb:AluOpLsb];
              state_q     <= StAluStart;
            end
            OP_HALT: begin
              retired_count_q <= retired_count_q + 8'd1;
              halted_q        <= 1'b1;
              state_q         <= StHalted;
            end
            default: begin
              err_q         <= 1'b1;
              instr_ready_q <= 1'b1;
              state_q       <= StFetch;
            end
          endcase
        end
        StAluStart: begin
          state_q <= StAluWait;
        end
        StAluWait: begin
          // A done on the final allowed cycle wins over the timeout.
          if (alu_done_i) begin
            we_reg_q     <= 1'b1;
            reg_select_q <= SEL_OUT;
            data_in_q    <= alu_result_i;
            state_q      <= StWrite;
          end else if (timer_expired) begin
            err_q         <= 1'b1;
            instr_ready_q <= 1'b1;
            state_q       <= StFetch;
          end
        end
        StWrite: begin
          retired_count_q <= retired_count_q + 8'd1;
          instr_ready_q   <= 1'b1;
          state_q         <= StFetch;
        end
        StHalted: begin
          if (resume_i) begin
            halted_q      <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= StFetch;
          end
        end
        default: begin
          instr_ready_q <= 1'b1;
          state_q       <= StFetch;
        end
      endcase
    end
  end

  assign instr_ready_o   = instr_ready_q;
  assign alu_start_o     = alu_start_q;
  assign alu_op_o        = alu_op_q;
  assign we_reg_o        = we_reg_q;
  assign reg_select_o    = reg_select_q;
  assign data_in_o       = data_in_q;
  assign halted_o        = halted_q;
  assign err_o           = err_q;
  assign retired_count_o = retired_count_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed self-checking bench for reg_write_sequencer.
module tb_reg_write_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic        alu_done;
  logic [7:0]  alu_result;
  logic        we_reg;
  logic [1:0]  reg_select;
  logic [7:0]  data_in;
  logic        resume;
  logic        halted;
  logic        err;
  logic [7:0]  retired_count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int we_cnt = 0;
  int snap;

  reg_write_sequencer #(
    .ALU_TIMEOUT (15),
    .DW          (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .instr_i         (instr),
    .alu_start_o     (alu_start),
    .alu_op_o        (alu_op),
    .alu_done_i      (alu_done),
    .alu_result_i    (alu_result),
    .we_reg_o        (we_reg),
    .reg_select_o    (reg_select),
    .data_in_o       (data_in),
    .resume_i        (resume),
    .halted_o        (halted),
    .err_o           (err),
    .retired_count_o (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles as seen at each active edge.
  always @(posedge clk) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    if (we_reg) we_cnt <= we_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present one instruction; returns one cycle after the handshake (DECODE).
  task automatic send(input logic [15:0] ins);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check_eq("send_ready_timeout", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_done    = 1'b0;
    alu_result  = 8'h00;
    resume      = 1'b0;
    apply_reset();

    // Reset state
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_we", we_reg, 0);
    check_eq("rst_alu_start", alu_start, 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_sel", reg_select, 0);
    check_eq("rst_data", data_in, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_count", retired_count, 0);

    // LDI A, 0x3C
    send(16'h103C);
    check_eq("ldi_dec_we", we_reg, 0);
    check_eq("ldi_dec_ready", instr_ready, 0);
    tick();
    check_eq("ldi_wr_we", we_reg, 1);
    check_eq("ldi_wr_sel", reg_select, 2'b00);
    check_eq("ldi_wr_data", data_in, 8'h3C);
    check_eq("ldi_wr_ready", instr_ready, 0);
    tick();
    check_eq("ldi_post_we", we_reg, 0);
    check_eq("ldi_post_ready", instr_ready, 1);
    check_eq("ldi_post_count", retired_count, 1);
    check_eq("ldi_post_data_hold", data_in, 8'h3C);

    // LDI B, 0x55
    send(16'h1455);
    tick();
    check_eq("ldib_we", we_reg, 1);
    check_eq("ldib_sel", reg_select, 2'b01);
    check_eq("ldib_data", data_in, 8'h55);
    tick();

    // LDI out, 0xC5
    send(16'h18C5);
    tick();
    check_eq("ldio_we", we_reg, 1);
    check_eq("ldio_sel", reg_select, 2'b10);
    check_eq("ldio_data", data_in, 8'hC5);
    tick();
    check_eq("ldio_count", retired_count, 3);

    // EXEC op 5, done in the third wait cycle
    snap = start_cnt;
    send(16'h2005);
    check_eq("exec_dec_start", alu_start, 0);
    tick();
    check_eq("exec_start", alu_start, 1);
    check_eq("exec_op", alu_op, 4'h5);
    tick();
    check_eq("exec_wait_start_low", alu_start, 0);
    check_eq("exec_wait_op_hold", alu_op, 4'h5);
    tick();
    tick();
    alu_done   = 1'b1;
    alu_result = 8'hA7;
    tick();
    alu_done = 1'b0;
    check_eq("exec_wr_we", we_reg, 1);
    check_eq("exec_wr_sel", reg_select, 2'b10);
    check_eq("exec_wr_data", data_in, 8'hA7);
    check_eq("exec_start_pulses", start_cnt - snap, 1);
    tick();
    check_eq("exec_post_we", we_reg, 0);
    check_eq("exec_post_ready", instr_ready, 1);
    check_eq("exec_post_count", retired_count, 4);

    // EXEC with done on the last allowed wait cycle (15th) succeeds
    send(16'h2009);
    tick();
    tick();
    repeat (14) tick();
    alu_done   = 1'b1;
    alu_result = 8'h5A;
    tick();
    alu_done = 1'b0;
    check_eq("edge_we", we_reg, 1);
    check_eq("edge_data", data_in, 8'h5A);
    check_eq("edge_err", err, 0);
    tick();
    check_eq("edge_count", retired_count, 5);

    // EXEC timeout: 15 wait cycles, then abort
    snap = we_cnt;
    send(16'h2003);
    tick();
    tick();
    check_eq("to_wait0_err", err, 0);
    repeat (14) tick();
    check_eq("to_wait14_err", err, 0);
    check_eq("to_wait14_ready", instr_ready, 0);
    tick();
    check_eq("to_err", err, 1);
    check_eq("to_ready", instr_ready, 1);
    check_eq("to_no_write", we_cnt - snap, 0);
    check_eq("to_count", retired_count, 5);
    // Stray done in FETCH
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    check_eq("stray_done_no_write", we_cnt - snap, 0);

    // Illegal opcode
    apply_reset();
    snap = we_cnt;
    send(16'h7000);
    tick();
    check_eq("ill_err", err, 1);
    check_eq("ill_ready", instr_ready, 1);
    check_eq("ill_count", retired_count, 0);

    // LDI with dst=11
    apply_reset();
    send(16'h1C3C);
    tick();
    check_eq("ldi11_err", err, 1);
    check_eq("ldi11_no_write", we_cnt - snap, 0);
    check_eq("ldi11_data", data_in, 0);
    check_eq("ldi11_count", retired_count, 0);

    // HALT then resume
    send(16'hF000);
    tick();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_ready", instr_ready, 0);
    check_eq("halt_count", retired_count, 1);
    repeat (3) tick();
    check_eq("halt_hold", halted, 1);
    check_eq("halt_hold_ready", instr_ready, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_eq("resume_halted", halted, 0);
    check_eq("resume_ready", instr_ready, 1);
    check_eq("resume_err_sticky", err, 1);

    // Reset during ALU_WAIT
    snap = we_cnt;
    send(16'h2001);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abw_ready", instr_ready, 1);
    check_eq("abw_err", err, 0);
    check_eq("abw_count", retired_count, 0);
    check_eq("abw_we", we_reg, 0);
    check_eq("abw_op", alu_op, 0);
    check_eq("abw_halted", halted, 0);
    tick();
    rst_n = 1'b1;
    alu_done   = 1'b1;
    alu_result = 8'h77;
    tick();
    alu_done = 1'b0;
    tick();
    check_eq("abw_late_done", we_cnt - snap, 0);
    check_eq("abw_late_data", data_in, 0);

    // Reset during ALU_START drops alu_start immediately
    send(16'h2002);
    tick();
    check_eq("abs_start_pre", alu_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abs_start", alu_start, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during WRITE drops we_reg immediately
    send(16'h1099);
    tick();
    check_eq("abwr_we_pre", we_reg, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abwr_we", we_reg, 0);
    check_eq("abwr_data", data_in, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 256 back-to-back NOPs: wrap and ready every second cycle
    instr       = 16'h0000;
    instr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      check_eq("nop_ready_hi", instr_ready, 1);
      tick();
      check_eq("nop_ready_lo", instr_ready, 0);
      if (i == 255) instr_valid = 1'b0;
      tick();
      if (i == 254) check_eq("nop_count_255", retired_count, 255);
    end
    check_eq("nop_count_wrap", retired_count, 0);
    check_eq("nop_final_ready", instr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Control stage directly upstream of the general-purpose register block (A, B, out) in the 8-bit crypto processor.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- For ALU operations, runs a start/done handshake with the ALU and enforces a timeout.
- Drives the register block's write port: we_reg, reg_select, data_in.

Parameters:
- ALU_TIMEOUT, 15, maximum cycles to wait for alu_done after alu_start before aborting. Legal range 1..255.
- DW, 8, datapath width; must match register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  instruction: [15:12] opcode, [11:10] dst, [7:0] imm, [3:0] alu op field.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_op  out  4  ALU operation code; held stable from alu_start until completion or timeout.
- alu_done  in  1  ALU result valid (single-cycle pulse).
- alu_result  in  DW  ALU result.
- we_reg  out  1  register write enable to the register block.
- reg_select  out  2  00=A, 01=B, 10=out.
- data_in  out  DW  register write data.
- resume  in  1  leave HALTED state.
- halted  out  1  sequencer is halted.
- err  out  1  sticky error flag: illegal instruction or ALU timeout.
- retired_count  out  8  count of retired instructions; wraps at 256.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to FETCH.
  - All outputs 0 except instr_ready=1.
  - Instruction register, timeout counter, err and retired_count cleared.
- Opcodes:
  - 0 = NOP.
  - 1 = LDI: write imm to dst.
  - 2 = EXEC: run ALU with op instr[3:0], write alu_result to out (sel 10).
  - F = HALT.
  - All others illegal.
- FETCH:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr and go to DECODE.
  - No other state asserts instr_ready.
- DECODE (1 cycle):
  - LDI with dst in {00,01,10} → WRITE with data=imm, sel=dst.
  - LDI with dst=11 → err=1, → FETCH.
  - EXEC → ALU_START.
  - NOP → FETCH, retire.
  - HALT → HALTED, retire.
  - Illegal opcode → err=1, → FETCH, not retired.
- ALU_START (1 cycle):
  - alu_start=1, alu_op=instr[3:0].
  - Timeout counter loaded with 0.
  - → ALU_WAIT.
- ALU_WAIT:
  - Counter increments each cycle.
  - On alu_done: capture alu_result, sel=10, → WRITE.
  - If the counter reaches ALU_TIMEOUT without alu_done: err=1, no write, → FETCH, not retired.
  - alu_done arriving in the same cycle the counter reaches ALU_TIMEOUT counts as success.
  - alu_done outside ALU_WAIT is ignored.
- WRITE (exactly 1 cycle):
  - we_reg=1, with reg_select and data_in registered and stable.
  - → FETCH, retire.
  - we_reg is 0 in every other state.
  - data_in and reg_select hold their last values outside WRITE.
- HALTED:
  - halted=1, instr_ready=0.
  - resume=1 → FETCH on the next edge. resume outside HALTED is ignored.
- Latency:
  - LDI: handshake at edge t, DECODE t+1, we_reg high t+2..t+3, instr_ready high again from t+3.
  - Minimum LDI throughput: 1 instruction per 3 cycles.
- Retire: retired_count increments by 1 modulo 256 (255→0).
- err stays set until reset.
- Reset mid-operation (e.g. during ALU_WAIT or WRITE): immediate abort; we_reg and alu_start drop asynchronously; no partial write.

Decomposition:
- Shared package (processor-wide): opcode constants (OP_NOP, OP_LDI, OP_EXEC, OP_HALT), register select constants (SEL_A, SEL_B, SEL_OUT), state enum, instruction field bit positions.
- One natural sub-module: seq_alu_timer, the timeout counter with load, enable and expired outputs, parameterised by ALU_TIMEOUT.
- FSM and output registers stay in the top module.

Test Plan:
- LDI: instr=0x1_0_3C (dst=A, imm=0x3C), valid for 1 cycle → we_reg=1 for exactly one cycle two edges after the handshake, sel=00, data_in=0x3C; retired_count=1.
- EXEC: instr=0x2005, alu_done after 3 cycles with alu_result=0xA7 → alu_start pulses once with alu_op=5; then we_reg=1, sel=10, data_in=0xA7.
- ALU timeout: EXEC with alu_done never asserted, ALU_TIMEOUT=15 → err=1 after 15 wait cycles; we_reg never asserted; instr_ready returns high; retired_count unchanged.
- Illegal cases: instr=0x7000 and LDI with dst=11 → err=1, no write. Then HALT (0xF000) → halted=1, instr_ready=0 until a resume pulse, then FETCH.
- Reset abort: rst_n low during ALU_WAIT → all outputs 0, instr_ready=1, err=0, count=0. A later alu_done causes no write.
- Wrap: 256 NOPs back-to-back → retired_count goes 255→0; instr_ready is high every second cycle.
